// File: rtl/timer.sv
// timer: memory-mapped prescaled up-counter with compare match, one-shot mode and a level interrupt.
module timer #(
    parameter logic [31:0] BASE_ADDR = 32'h40A0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [1:0]  mode,
    input  logic [1:0]  reqw,
    input  logic        reqs,
    output logic [31:0] read_data,
    output logic        irq
);
    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_STATUS  = 32'h04;
    localparam logic [31:0] OFF_PRESC   = 32'h08;
    localparam logic [31:0] OFF_COUNTER = 32'h0C;
    localparam logic [31:0] OFF_COMPARE = 32'h10;
    localparam logic [31:0] OFF_PSC_CNT = 32'h14;

    // CTRL bit positions
    localparam int EN      = 0;
    localparam int IRQ_EN  = 1;
    localparam int ONESHOT = 2;

    logic [2:0]  ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] compare_q, compare_d;
    logic [15:0] psc_cnt_q, psc_cnt_d;

    logic [31:0] offset;
    logic [31:0] wmask;
    logic        wr;
    logic        wr_ctrl, wr_status, wr_presc, wr_counter, wr_compare;
    logic [2:0]  ctrl_wval;
    logic        en_rise;
    logic        tick;
    logic        hit;
    logic        unused;

    // The sign-extend request only matters to slaves that return narrow data.
    assign unused = reqs;

    // Address decode, write strobes and the byte/halfword/word merge mask.
    always_comb begin
        offset     = address - BASE_ADDR;
        wr         = select && (mode == 2'b10);
        wmask      = (reqw == 2'b00) ? 32'h0000_00FF :
                     (reqw == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        wr_ctrl    = wr && (offset == OFF_CTRL);
        wr_status  = wr && (offset == OFF_STATUS);
        wr_presc   = wr && (offset == OFF_PRESC);
        wr_counter = wr && (offset == OFF_COUNTER);
        wr_compare = wr && (offset == OFF_COMPARE);
        ctrl_wval  = (ctrl_q & ~wmask[2:0]) | (write_data[2:0] & wmask[2:0]);
        en_rise    = wr_ctrl && !ctrl_q[EN] && ctrl_wval[EN];
    end

    // Prescaler tick and compare match; a match only counts on a tick.
    always_comb begin
        tick = ctrl_q[EN] && (psc_cnt_q == presc_q);
        hit  = tick && (counter_q == compare_q);
    end

    // Prescale counter: free-runs while enabled, restarts on prescaler write or enable.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (ctrl_q[EN])
            psc_cnt_d = tick ? 16'd0 : psc_cnt_q + 16'd1;
        if (wr_presc || en_rise)
            psc_cnt_d = 16'd0;
    end

    // Main counter: advances on tick, clears on match, bus write takes priority.
    always_comb begin
        counter_d = counter_q;
        if (tick)
            counter_d = hit ? 32'd0 : counter_q + 32'd1;
        if (wr_counter)
            counter_d = (counter_q & ~wmask) | (write_data & wmask);
    end

    // Overflow flag: write-1-to-clear, but a same-cycle match keeps it set.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && write_data[0])
            ovf_d = 1'b0;
        if (hit)
            ovf_d = 1'b1;
    end

    // Control, prescaler and compare registers; a CTRL write beats the one-shot stop.
    always_comb begin
        ctrl_d = ctrl_q;
        if (hit && ctrl_q[ONESHOT])
            ctrl_d[EN] = 1'b0;
        if (wr_ctrl)
            ctrl_d = ctrl_wval;
        presc_d   = wr_presc   ? (presc_q & ~wmask[15:0]) | (write_data[15:0] & wmask[15:0]) : presc_q;
        compare_d = wr_compare ? (compare_q & ~wmask) | (write_data & wmask) : compare_q;
    end

    // State registers with synchronous active-low reset overriding everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q    <= 3'd0;
            ovf_q     <= 1'b0;
            presc_q   <= 16'd0;
            counter_q <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            psc_cnt_q <= 16'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            presc_q   <= presc_d;
            counter_q <= counter_d;
            compare_q <= compare_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end

    // Zero-latency read mux; unmapped offsets return zero.
    always_comb begin
        case (offset)
            OFF_CTRL:    read_data = {29'd0, ctrl_q};
            OFF_STATUS:  read_data = {31'd0, ovf_q};
            OFF_PRESC:   read_data = {16'd0, presc_q};
            OFF_COUNTER: read_data = counter_q;
            OFF_COMPARE: read_data = compare_q;
            OFF_PSC_CNT: read_data = {16'd0, psc_cnt_q};
            default:     read_data = 32'd0;
        endcase
        irq = ovf_q && ctrl_q[IRQ_EN];
    end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed register-level checks of the timer slave.
module tb_timer;
    localparam logic [31:0] BASE = 32'h40A0;

    logic        clk;
    logic        reset_n;
    logic        select;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  mode;
    logic [1:0]  reqw;
    logic        reqs;
    logic [31:0] read_data;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .select(select), .address(address),
        .write_data(write_data), .mode(mode), .reqw(reqw), .reqs(reqs),
        .read_data(read_data), .irq(irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [1:0] w);
        select = 1'b1; mode = 2'b10; address = BASE + off; write_data = d; reqw = w;
        @(posedge clk);
        #1;
        select = 1'b0; mode = 2'b00;
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        select = 1'b1; mode = 2'b01; address = BASE + off;
        #1;
        chk(tag, read_data, exp);
        select = 1'b0; mode = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0; select = 1'b0; mode = 2'b00; address = 32'd0;
        write_data = 32'd0; reqw = 2'b10; reqs = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        rd("rst_ctrl", 32'h00, 32'h0);
        rd("rst_status", 32'h04, 32'h0);
        rd("rst_presc", 32'h08, 32'h0);
        rd("rst_counter", 32'h0C, 32'h0);
        rd("rst_compare", 32'h10, 32'hFFFF_FFFF);
        rd("rst_psc_cnt", 32'h14, 32'h0);
        rd("rst_unmapped", 32'h18, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);

        // prescaled periodic counting with interrupt
        wr(32'h08, 32'd3, 2'b10);
        wr(32'h10, 32'd2, 2'b10);
        wr(32'h00, 32'd3, 2'b10);
        rd("per_cnt_e0", 32'h0C, 32'd0);
        cyc(3); rd("per_cnt_e3", 32'h0C, 32'd0);
        cyc(1); rd("per_cnt_e4", 32'h0C, 32'd1);
        cyc(4); rd("per_cnt_e8", 32'h0C, 32'd2);
        cyc(3); rd("per_ovf_e11", 32'h04, 32'd0);
        cyc(1); rd("per_cnt_e12", 32'h0C, 32'd0);
        rd("per_ovf_e12", 32'h04, 32'd1);
        chk("per_irq", {31'd0, irq}, 32'h1);

        // one-shot
        wr(32'h00, 32'd0, 2'b10);
        wr(32'h04, 32'd1, 2'b10);
        chk("w1c_irq_low", {31'd0, irq}, 32'h0);
        wr(32'h0C, 32'd0, 2'b10);
        wr(32'h08, 32'd0, 2'b10);
        wr(32'h10, 32'd1, 2'b10);
        wr(32'h00, 32'd5, 2'b10);
        cyc(1); rd("os_cnt1", 32'h0C, 32'd1);
        cyc(1); rd("os_cnt2", 32'h0C, 32'd0);
        rd("os_ovf", 32'h04, 32'd1);
        rd("os_ctrl", 32'h00, 32'd4);
        chk("os_irq", {31'd0, irq}, 32'h0);
        cyc(3); rd("os_hold", 32'h0C, 32'd0);

        // write priority over tick; overflow beats W1C
        wr(32'h04, 32'd1, 2'b10);
        wr(32'h10, 32'h1000, 2'b10);
        wr(32'h00, 32'd1, 2'b10);
        wr(32'h0C, 32'h55, 2'b10);
        rd("pri_cnt_write", 32'h0C, 32'h55);
        cyc(1); rd("pri_cnt_next", 32'h0C, 32'h56);
        wr(32'h0C, 32'h1000, 2'b10);
        wr(32'h04, 32'd1, 2'b10);
        rd("pri_ovf_set_wins", 32'h04, 32'd1);
        rd("pri_cnt_wrap", 32'h0C, 32'd0);
        wr(32'h04, 32'd1, 2'b10);
        rd("pri_w1c", 32'h04, 32'd0);

        // partial writes and ignored writes
        wr(32'h00, 32'd0, 2'b10);
        wr(32'h10, 32'h1234_5678, 2'b10);
        wr(32'h10, 32'hAB, 2'b00);
        rd("byte_cmp", 32'h10, 32'h1234_56AB);
        wr(32'h10, 32'hFFFF_CDEF, 2'b01);
        rd("half_cmp", 32'h10, 32'h1234_CDEF);
        wr(32'h08, 32'd5, 2'b10);
        wr(32'h00, 32'd1, 2'b10);
        cyc(2);
        wr(32'h00, 32'd0, 2'b10);
        rd("psc_cnt_run", 32'h14, 32'd3);
        wr(32'h14, 32'hBEEF, 2'b01);
        rd("psc_cnt_ro", 32'h14, 32'd3);
        wr(32'h18, 32'hFFFF_FFFF, 2'b10);
        rd("unmapped_wr", 32'h18, 32'd0);
        select = 1'b0; mode = 2'b10; address = BASE + 32'h10; write_data = 32'd0; reqw = 2'b10;
        @(posedge clk);
        #1;
        mode = 2'b00;
        rd("nosel_cmp", 32'h10, 32'h1234_CDEF);

        // unreachable compare: natural wrap without overflow
        wr(32'h08, 32'd0, 2'b10);
        wr(32'h10, 32'hFFFF_FFFE, 2'b10);
        wr(32'h0C, 32'hFFFF_FFFF, 2'b10);
        wr(32'h00, 32'd3, 2'b10);
        rd("wrap_pre", 32'h0C, 32'hFFFF_FFFF);
        cyc(1); rd("wrap_cnt", 32'h0C, 32'd0);
        rd("wrap_ovf", 32'h04, 32'd0);
        chk("wrap_irq", {31'd0, irq}, 32'h0);
        cyc(1); rd("wrap_next", 32'h0C, 32'd1);

        // reset while running, with a concurrent write
        reset_n = 1'b0;
        wr(32'h0C, 32'h77, 2'b10);
        reset_n = 1'b1;
        rd("rr_ctrl", 32'h00, 32'h0);
        rd("rr_status", 32'h04, 32'h0);
        rd("rr_presc", 32'h08, 32'h0);
        rd("rr_counter", 32'h0C, 32'h0);
        rd("rr_compare", 32'h10, 32'hFFFF_FFFF);
        rd("rr_psc_cnt", 32'h14, 32'h0);
        chk("rr_irq", {31'd0, irq}, 32'h0);
        cyc(2); rd("rr_hold", 32'h0C, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
